// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
//   arb_state_t          : arbiter FSM state (idle, owned by master 0, owned by master 1)
//   DefaultTimeoutCycles : default watchdog limit
//   rr_pick()            : round-robin owner choice from the request pair and the last owner
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_t;

    localparam int unsigned DefaultTimeoutCycles = 1024;

    // Returns the index of the master to grant. On a tie the master that did not
    // own the bus last wins. The result is meaningless when req is 00.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
        logic owner;
        owner = 1'b0;
        case (req)
            2'b01:   owner = 1'b0;
            2'b10:   owner = 1'b1;
            2'b11:   owner = ~last_owner;
            default: owner = 1'b0;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Stall watchdog for the arbiter's slave port. Counts consecutive cycles in which the
// current owner strobes without an acknowledge and raises a one-cycle error pulse when
// the limit is reached, then starts counting again.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   cyc_i      : owner's bus tenure (low also means no owner / ownership change)
//   stb_i      : owner's raw strobe
//   ack_i      : slave acknowledge
//   err_o      : one-cycle error pulse (combinational, suppressed by ack)
module wb_timeout_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic err_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            stalled;

    // The owner's cyc drops on every cycle that leads to a state change, so gating with
    // cyc also clears the count across ownership changes.
    assign stalled = cyc_i & stb_i & ~ack_i;
    assign err_o   = stalled & (count_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = '0;
        if (stalled && !err_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single slave port.
// Master 0 is the processor core, master 1 a controller-side agent (DMA, debug loader).
// The slave is granted for a whole tenure (cyc high); ties alternate round-robin and a
// releasing owner hands over directly to a waiting master without an idle bubble.
// Optional stall watchdog: define WB_ARBITER_TIMEOUT_EN to enable it.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   mN_cyc_i..mN_data_i : master N request side (N = 0, 1)
//   mN_data_o           : slave read data, routed to both masters
//   mN_ack_o, mN_err_o  : acknowledge / watchdog error to master N
//   s_*                 : slave port
//   grant_o             : one-hot current owner, 00 when idle
module wb_bus_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,

    output logic [1:0]            grant_o
);

    arb_state_t state_q;
    logic       last_owner_q;
    logic [1:0] grant_q;
    logic       wd_err;

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign grant_o   = grant_q;

    // Ownership FSM. The grant is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            grant_q      <= 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        if (rr_pick({m1_cyc_i, m0_cyc_i}, last_owner_q)) begin
                            state_q <= StOwn1;
                            grant_q <= 2'b10;
                        end else begin
                            state_q <= StOwn0;
                            grant_q <= 2'b01;
                        end
                    end
                end
                StOwn0: begin
                    if (!m0_cyc_i) begin
                        last_owner_q <= 1'b0;
                        if (m1_cyc_i) begin
                            state_q <= StOwn1;
                            grant_q <= 2'b10;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= 2'b00;
                        end
                    end
                end
                StOwn1: begin
                    if (!m1_cyc_i) begin
                        last_owner_q <= 1'b1;
                        if (m0_cyc_i) begin
                            state_q <= StOwn0;
                            grant_q <= 2'b01;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Bus routing: the owner sees the slave, everything else is held at zero.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            StOwn0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~wd_err;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                m0_ack_o = s_ack_i;
                m0_err_o = wd_err;
            end
            StOwn1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~wd_err;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i;
                m1_err_o = wd_err;
            end
            default: ;
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    logic own_cyc;
    logic own_stb;

    // Raw owner strobe, taken before the watchdog masks it to avoid a feedback path.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            StOwn0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
            end
            StOwn1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    wb_timeout_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .cyc_i (own_cyc),
        .stb_i (own_stb),
        .ack_i (s_ack_i),
        .err_o (wd_err)
    );
`else
    assign wd_err = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;
    import wb_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_ack;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]    grant;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t sb_q[$];

    wb_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_addr_i (m0_addr),
        .m0_data_i (m0_wdata),
        .m0_data_o (m0_rdata),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_addr_i (m1_addr),
        .m1_data_i (m1_wdata),
        .m1_data_o (m1_rdata),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_data_i  (s_rdata),
        .s_ack_i   (s_ack),
        .grant_o   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every acknowledged slave transfer must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && s_cyc && s_stb && s_ack) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got addr=%h grant=%b, expected no transfer",
                         s_addr, grant);
            end else begin
                txn_t exp_t;
                exp_t = sb_q.pop_front();
                if ({grant, s_we, s_addr, s_wdata} !== {exp_t.grant, exp_t.we, exp_t.addr, exp_t.data}) begin
                    n_errors++;
                    $display("FAIL sb_txn: got grant=%b we=%b addr=%h data=%h, expected grant=%b we=%b addr=%h data=%h",
                             grant, s_we, s_addr, s_wdata,
                             exp_t.grant, exp_t.we, exp_t.addr, exp_t.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        s_ack = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        // Master inputs and slave ack active during reset must not leak through.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h0000_0ABC; m0_wdata = 32'h1234_5678;
        s_ack = 1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_errors++; $display("FAIL reset_grant: got %b, expected 00", grant);
        end
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_addr, s_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b addr=%h data=%h, expected all 0",
                     s_cyc, s_stb, s_we, s_addr, s_wdata);
        end
        n_checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_resp: got %b, expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        step();
        idle_inputs();
        rst_n = 1;
        step();
    endtask

    task automatic test_single_write();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (s_cyc !== 1'b0 || grant !== 2'b00) begin
            n_errors++;
            $display("FAIL write_latency: got s_cyc=%b grant=%b, expected 0/00", s_cyc, grant);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (s_cyc !== 1'b1 || grant !== 2'b01 || m0_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL write_grant: got s_cyc=%b grant=%b ack=%b, expected 1/01/0",
                     s_cyc, grant, m0_ack);
        end
        step();
        sb_q.push_back('{grant: 2'b01, we: 1'b1, addr: 32'h100, data: 32'hDEAD_BEEF});
        s_ack = 1;
        @(negedge clk);
        n_checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL write_ack: got m0_ack=%b m1_ack=%b, expected 1/0", m0_ack, m1_ack);
        end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_errors++; $display("FAIL write_release: got grant=%b, expected 00", grant);
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h200; m0_wdata = 32'h0000_0002;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300; m1_wdata = 32'h0000_0003;
        step();
        sb_q.push_back('{grant: 2'b01, we: 1'b0, addr: 32'h200, data: 32'h0000_0002});
        s_ack = 1;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_first: got grant=%b m0_ack=%b m1_ack=%b, expected 01/1/0",
                     grant, m0_ack, m1_ack);
        end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        n_checks++;
        if (s_cyc !== 1'b0 || grant !== 2'b01) begin
            n_errors++;
            $display("FAIL tie_release: got s_cyc=%b grant=%b, expected 0/01", s_cyc, grant);
        end
        step();
        sb_q.push_back('{grant: 2'b10, we: 1'b0, addr: 32'h300, data: 32'h0000_0003});
        s_ack = 1;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_handover: got grant=%b m1_ack=%b m0_ack=%b, expected 10/1/0",
                     grant, m1_ack, m0_ack);
        end
        step();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step();
    endtask

    task automatic test_burst();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h0; m1_wdata = '0;
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h400; m0_wdata = 32'h55AA_55AA;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] rd;
            rd = 32'hA000_0000 + DW'(i);
            m1_addr = AW'(i * 4);
            s_rdata = rd;
            s_ack = 1;
            sb_q.push_back('{grant: 2'b10, we: 1'b0, addr: AW'(i * 4), data: '0});
            @(negedge clk);
            n_checks++;
            if (m1_ack !== 1'b1 || m1_rdata !== rd || m0_ack !== 1'b0 || grant !== 2'b10) begin
                n_errors++;
                $display("FAIL burst_beat%0d: got m1_ack=%b rdata=%h m0_ack=%b grant=%b, expected 1/%h/0/10",
                         i, m1_ack, m1_rdata, m0_ack, grant, rd);
            end
            step();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clk);
        n_checks++;
        if (m0_ack !== 1'b0 || grant !== 2'b10) begin
            n_errors++;
            $display("FAIL burst_stall: got m0_ack=%b grant=%b, expected 0/10", m0_ack, grant);
        end
        step();
        sb_q.push_back('{grant: 2'b01, we: 1'b1, addr: 32'h400, data: 32'h55AA_55AA});
        s_ack = 1;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01 || m0_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL burst_next_owner: got grant=%b m0_ack=%b, expected 01/1", grant, m0_ack);
        end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        step();
    endtask

    task automatic test_idle_ack();
        m0_stb = 1; m0_addr = 32'h1234; s_ack = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_ack, m1_ack, s_cyc, s_stb, grant} !== 6'b0) begin
                n_errors++;
                $display("FAIL idle_ack: got m0_ack=%b m1_ack=%b s_cyc=%b s_stb=%b grant=%b, expected all 0",
                         m0_ack, m1_ack, s_cyc, s_stb, grant);
            end
            n_checks++;
            if (s_addr !== '0) begin
                n_errors++; $display("FAIL idle_addr: got %h, expected 0", s_addr);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h500;
        step();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10) begin
            n_errors++; $display("FAIL rstmid_own1: got grant=%b, expected 10", grant);
        end
        step();
        rst_n = 0;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h600;
        step();
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_idle: got grant=%b s_cyc=%b s_stb=%b, expected 00/0/0",
                     grant, s_cyc, s_stb);
        end
        step();
        @(negedge clk);
        // last_owner reset to 1, so the tie goes to master 0.
        n_checks++;
        if (grant !== 2'b01) begin
            n_errors++; $display("FAIL rstmid_last_owner: got grant=%b, expected 01", grant);
        end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        pulses = 0;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h700; m0_wdata = 32'h7;
        step();
        for (int i = 0; i < 12; i++) begin
            logic exp_err;
`ifdef WB_ARBITER_TIMEOUT_EN
            exp_err = (i == int'(TO) - 1);
`else
            exp_err = 1'b0;
`endif
            @(negedge clk);
            if (m0_err === 1'b1) pulses++;
            n_checks++;
            if (m0_err !== exp_err || s_stb !== ~exp_err || m1_err !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout_cycle%0d: got err=%b s_stb=%b m1_err=%b, expected %b/%b/0",
                         i, m0_err, s_stb, m1_err, exp_err, ~exp_err);
            end
            step();
        end
        n_checks++;
`ifdef WB_ARBITER_TIMEOUT_EN
        if (pulses != 1) begin
            n_errors++; $display("FAIL timeout_pulses: got %0d, expected 1", pulses);
        end
`else
        if (pulses != 0) begin
            n_errors++; $display("FAIL timeout_pulses: got %0d, expected 0", pulses);
        end
`endif
        idle_inputs();
        step();
        step();
        // Ack on the limit cycle wins over the error.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h704; m0_wdata = 32'h8;
        step();
        for (int i = 0; i < int'(TO); i++) begin
            if (i == int'(TO) - 1) begin
                s_ack = 1;
                sb_q.push_back('{grant: 2'b01, we: 1'b1, addr: 32'h704, data: 32'h8});
            end
            @(negedge clk);
            if (i == int'(TO) - 1) begin
                n_checks++;
                if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL timeout_ack_priority: got ack=%b err=%b, expected 1/0",
                             m0_ack, m0_err);
                end
            end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_write();
        test_tie_handover();
        test_burst();
        test_idle_ack();
        test_reset_mid();
        test_timeout();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending transfers, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
